// File: rtl/sync_ram_ctrl_if.sv
// Request/response bundle for sync_ram_ctrl.
// Master issues requests and consumes responses; slave is the RAM controller.
interface sync_ram_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 16
) ();
    logic                req_valid;
    logic                req_ready;
    logic                req_wen;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wmask;
    logic                resp_valid;
    logic                resp_ready;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_err;
    logic                resp_wr;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_wr
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_wr
    );
endinterface

// File: rtl/sync_ram_ctrl.sv
// Single-port on-chip RAM with valid/ready request and response channels,
// byte-masked writes, configurable read latency and out-of-range reporting.
module sync_ram_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    sync_ram_ctrl_if.slave bus
);
    localparam int MAX_OUT = RD_LAT + 1;
    localparam int NB      = DATA_W / 8;
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW      = $clog2(MAX_OUT + 1);
    localparam int PW      = $clog2(MAX_OUT);
    localparam int L       = RD_LAT - 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [CW-1:0]     r_cnt;
    logic              w_ready;
    logic              w_acc;
    logic              w_pop;
    logic              w_in_range;
    logic [IW-1:0]     w_idx;

    logic              r_pv [RD_LAT];
    logic              r_pe [RD_LAT];
    logic              r_pw [RD_LAT];
    logic [DATA_W-1:0] r_pd [RD_LAT];

    logic [DATA_W-1:0] r_fd [MAX_OUT];
    logic              r_fe [MAX_OUT];
    logic              r_fw [MAX_OUT];
    logic [PW-1:0]     r_rp;
    logic [PW-1:0]     r_wp;
    logic [CW-1:0]     r_fc;
    logic              w_fempty;
    logic              w_push;
    logic              w_fpop;
    logic              w_valid;
    logic [DATA_W-1:0] w_odata;
    logic              w_oerr;
    logic              w_owr;

    // Credit is the count of accepted-but-unpopped requests, so the
    // response FIFO can never overflow and ready has no path from resp_ready.
    assign w_ready    = !rst && (r_cnt < CW'(MAX_OUT));
    assign w_acc      = bus.req_valid && w_ready;
    assign w_in_range = {1'b0, bus.req_addr} < DEPTH_V;
    assign w_idx      = bus.req_addr[IW-1:0];

    assign w_fempty = (r_fc == '0);
    assign w_valid  = !w_fempty || r_pv[L];
    assign w_pop    = !rst && w_valid && bus.resp_ready;
    assign w_fpop   = !w_fempty && bus.resp_ready;
    assign w_push   = r_pv[L] && !(w_fempty && bus.resp_ready);

    // Outstanding request counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_acc && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_acc && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Commit byte-masked writes at the accept edge; reset never touches memory
    always_ff @(posedge clk) begin
        if (w_acc && bus.req_wen && w_in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline valid bits, flushed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    // Read pipeline payload: memory sampled at accept, zero for writes/errors
    always_ff @(posedge clk) begin
        r_pw[0] <= bus.req_wen;
        r_pe[0] <= !w_in_range;
        r_pd[0] <= (!bus.req_wen && w_in_range) ? r_mem[w_idx] : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            r_pw[i] <= r_pw[i-1];
            r_pe[i] <= r_pe[i-1];
            r_pd[i] <= r_pd[i-1];
        end
    end

    // Response FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rp <= '0;
            r_wp <= '0;
            r_fc <= '0;
        end else begin
            if (w_push) begin
                r_wp <= (r_wp == PW'(MAX_OUT - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_fpop) begin
                r_rp <= (r_rp == PW'(MAX_OUT - 1)) ? '0 : r_rp + 1'b1;
            end
            if (w_push && !w_fpop) begin
                r_fc <= r_fc + 1'b1;
            end else if (!w_push && w_fpop) begin
                r_fc <= r_fc - 1'b1;
            end
        end
    end

    // Response FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fd[r_wp] <= r_pd[L];
            r_fe[r_wp] <= r_pe[L];
            r_fw[r_wp] <= r_pw[L];
        end
    end

    // Fall-through: pipeline output is presented directly when FIFO is empty
    always_comb begin
        w_odata = r_pd[L];
        w_oerr  = r_pe[L];
        w_owr   = r_pw[L];
        if (!w_fempty) begin
            w_odata = r_fd[r_rp];
            w_oerr  = r_fe[r_rp];
            w_owr   = r_fw[r_rp];
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = !rst && w_valid;
    assign bus.resp_rdata = bus.resp_valid ? w_odata : '0;
    assign bus.resp_err   = bus.resp_valid && w_oerr;
    assign bus.resp_wr    = bus.resp_valid && w_owr;
endmodule
